// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared state encodings and constants for the UART instruction loader
package instr_loader_pkg;
  typedef enum logic {LD_LOAD = 1'b0, LD_DONE = 1'b1} ld_state_t;
  localparam logic [31:0] HALT_DEFAULT = 32'h0000_0000;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: MSB-first byte-to-word shifter with inter-byte timeout
module byte_assembler
  import instr_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        rx_done,
  input  logic [7:0]  rx_byte,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        timeout
);
  logic [23:0] r_shift;
  logic [1:0]  r_idx;
  logic [31:0] r_cnt;
  logic        w_take;
  assign w_take     = en && !clr && rx_done;
  assign word       = {r_shift, rx_byte};
  assign word_valid = w_take && r_idx == 2'(BYTES_PER_WORD - 1);
  // a byte arriving in the expiry cycle wins over the timeout
  assign timeout    = en && !clr && !rx_done && r_idx != 2'd0 && r_cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_shift <= {r_shift[15:0], rx_byte};
      r_idx   <= r_idx + 2'd1;
      r_cnt   <= '0;
    end else if (timeout) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (en && r_idx != 2'd0) begin
      r_cnt <= r_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles UART bytes into words and writes them to instruction memory
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int          MEM_DEPTH      = 256,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [31:0] HALT_WORD      = HALT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_done,
  input  logic [7:0]  rx_byte,
  input  logic        reload,
  output logic        write_instruction,
  output logic [31:0] instr_address,
  output logic [31:0] instruction,
  output logic        load_done,
  output logic [31:0] word_count,
  output logic        timeout_err
);
  ld_state_t   r_state, w_next;
  logic        r_write, r_terr, w_word_valid, w_timeout, w_last;
  logic [31:0] r_addr, r_instr, r_count, w_word;
  byte_assembler #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (reload),
    .en         (r_state == LD_LOAD),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte),
    .word_valid (w_word_valid),
    .word       (w_word),
    .timeout    (w_timeout)
  );
  always_comb begin
    w_last = r_instr == HALT_WORD || r_addr == 32'(MEM_DEPTH - 1);
    w_next = reload ? LD_LOAD : (r_state == LD_LOAD && r_write && w_last) ? LD_DONE : r_state;
  end
  always_ff @(posedge clk) r_state <= rst ? LD_LOAD : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_count <= '0;
      r_terr  <= 1'b0;
    end else if (reload) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_count <= '0;
      r_terr  <= 1'b0;
    end else begin
      r_write <= w_word_valid;
      if (w_word_valid) r_instr <= w_word;
      if (w_timeout) r_terr <= 1'b1;
      // the final write keeps its address; the count still includes it
      if (r_write) begin
        r_count <= r_count + 32'd1;
        if (!w_last) r_addr <= r_addr + 32'd1;
      end
    end
  end
  assign write_instruction = r_write;
  assign instr_address     = r_addr;
  assign instruction       = r_instr;
  assign word_count        = r_count;
  assign timeout_err       = r_terr;
  assign load_done         = r_state == LD_DONE;
endmodule

// File: doc/instr_loader.md
# instr_loader

Upstream companion of the debug unit on the UART path: consumes the byte stream from the UART receiver and assembles big-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses starting at 0, until a halt word or the memory depth ends the load. Its `load_done` level is the condition the debug unit waits on before it starts execution and dump.

## Interface

Parameters:
- `MEM_DEPTH`, default 256: instruction memory depth in words; the last writable address is MEM_DEPTH-1.
- `TIMEOUT_CYCLES`, default 100000: maximum idle gap between bytes of one word before the partial word is discarded.
- `HALT_WORD`, default 32'h0000_0000: word that terminates loading.

Ports:
- `clk`  in  1  single clock; everything is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `rx_done`  in  1  one-cycle strobe: `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `reload`  in  1  one-cycle request to restart loading from address 0.
- `write_instruction`  out  1  one-cycle memory write-enable pulse.
- `instr_address`  out  32  word address for the current or next write.
- `instruction`  out  32  assembled word; held stable while `write_instruction`=1.
- `load_done`  out  1  level: loading finished.
- `word_count`  out  32  words written since reset or reload, range 0..MEM_DEPTH.
- `timeout_err`  out  1  sticky: a partial word was discarded.

## Operation

- Reset values: every output 0. The state machine resets to LOAD with byte index 0, timeout counter 0 and address pointer 0.
- State machine: LOAD and DONE.
  - LOAD: each `rx_done` shifts `rx_byte` in, MSB first, and increments the byte index (0..3).
  - On the 4th byte the word completes: `instruction` <= word, `write_instruction` <= 1, byte index <= 0.
- Post-write, at the edge after the pulse: `write_instruction` <= 0, `instr_address` += 1, `word_count` += 1.
- Termination: the completed word is always written, including `HALT_WORD`. After that write, if the word equals `HALT_WORD` or `instr_address` == MEM_DEPTH-1, move to DONE and set `load_done`=1.
  - In this case `instr_address` does not increment; `word_count` still increments.
- DONE: `rx_done` is ignored and no writes occur. Only `reload` or `rst` leaves DONE.
- `reload` (accepted in either state) goes to LOAD and clears the address pointer, `word_count`, byte index, timeout counter, `load_done` and `timeout_err`. It also forces `write_instruction` to 0.
- Timeout:
  - While byte index ≠ 0 in LOAD, the counter increments every cycle without `rx_done` and clears on `rx_done`.
  - On reaching TIMEOUT_CYCLES: byte index <= 0, the partial word is dropped (no write), `timeout_err` <= 1, counter <= 0.
  - While byte index = 0 the counter holds at 0.
- Simultaneous events:
  - `reload` + `rx_done`: reload wins and the byte is dropped.
  - `rx_done` + timeout expiry in the same cycle: the byte is accepted and the counter clears.
  - `rst` overrides everything.
- Reset mid-word or mid-pulse clears everything to the reset values on the next edge; there is no partial write.

## Timing

- Write latency: `write_instruction` rises at the edge that samples the 4th `rx_done`, so it is visible 1 cycle after the strobe cycle. It is exactly 1 cycle wide.
- `instr_address` and `instruction` are stable for the whole pulse cycle. The address advances at the edge that ends the pulse.
- `load_done` rises at the edge that ends the final write pulse.
- Back-to-back `rx_done` strobes on every cycle are supported: the minimum word period is 4 cycles. Write pulses are therefore never adjacent.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure

- Shared package holds:
  - state encodings `LD_LOAD`/`LD_DONE`;
  - the default `HALT_WORD`;
  - the byte-per-word constant (4).
- One sub-module, `byte_assembler`: MSB-first shift register, byte index and timeout counter.
  - Outputs a one-cycle `word_valid` with the assembled `word` and a `timeout` pulse.
  - Inputs: `clr`, driven by reload, and `en`, high in LOAD.
- The top level holds the LOAD/DONE machine, the address pointer, `word_count` and the output registers.

## Test plan

- Bytes 12 34 56 78 then 9A BC DE F0 → two pulses: addr 0 / 0x12345678, then addr 1 / 0x9ABCDEF0; `word_count`=2; `load_done`=0.
- Words 0x20010005, 0x00000000 → both written (addr 0, addr 1); `load_done`=1; `word_count`=2; further bytes 11 22 33 44 produce no pulse.
- MEM_DEPTH=4 with 5 non-halt words → writes at addr 0..3 only; `load_done` after the 4th write; `instr_address` stays 3; 5th word ignored.
- Bytes AA BB, then a gap of TIMEOUT_CYCLES, then 01 02 03 04 → no write for AA BB; `timeout_err`=1; next write is addr 0 / 0x01020304.
- `rst` after byte 2 of a word, then 4 bytes 00 00 00 07 → clean restart with a single write at addr 0 / 0x00000007.
- In DONE, `reload` pulsed in the same cycle as `rx_done` → that byte is dropped; `load_done`=0, `timeout_err`=0, `word_count`=0; the next 4 bytes write at addr 0.
